fxp_seqmult: RTL and testbench

- Parametrised sequential signed fixed-point multiplier for two's-complement Q(P.Q) operands (P integer bits incl. sign, Q fraction bits, N=P+Q).
- Radix-2 shift-add datapath on operand magnitudes, followed by a registered round/saturate stage.
- Four rounding modes, selectable saturate-or-wrap, sticky-free per-result status flags.
- Full valid/ready handshake on both sides, with back-to-back issue; successor of the fixed Q8.8 multiplier in the arithmetic datapath.

---
 rtl/fxp_pkg.sv | 23 ++
 rtl/fxp_round_sat.sv | 57 +++++
 rtl/fxp_seqmult.sv | 103 ++++++++++
 tb/tb_fxp_seqmult.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared types and constants for the sequential fixed-point multiplier.
package fxp_pkg;

  typedef enum logic [1:0] {
    RND_NE   = 2'd0,
    RND_TZ   = 2'd1,
    RND_PINF = 2'd2,
    RND_NINF = 2'd3
  } round_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int OOR_POS = 0;
  localparam int OOR_NEG = 1;
  localparam int OOR_UNF = 2;
  localparam int OOR_INX = 3;

endpackage

// File: rtl/fxp_round_sat.sv
// Rounds a 2N-bit product magnitude (2Q fraction bits) to signed Q(P.Q),
// then saturates or wraps and reports overflow/underflow/inexact status.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int P = 8,
  parameter int Q = 8,
  localparam int N = P + Q
) (
  input  logic [2*N-1:0] mag,
  input  logic           sign,
  input  logic [1:0]     mode,
  input  logic           sat,
  output logic [N-1:0]   res,
  output logic [3:0]     oor
);

  localparam int KW = N + Q;
  localparam logic [2*N-1:0] STICKY_MASK = {(2*N){1'b1}} >> (2*N - Q + 1);
  localparam logic [KW:0]    POS_LIM     = {{(Q+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic [KW:0]    NEG_LIM     = POS_LIM + 1'b1;

  logic [KW-1:0] kept;
  logic [KW:0]   rounded;
  logic [N-1:0]  wrapped;
  logic          guard, sticky, inexact, inc, pos_ovf, neg_ovf;

  always_comb begin
    kept    = mag[2*N-1:Q];
    guard   = mag[Q-1];
    sticky  = |(mag & STICKY_MASK);
    inexact = guard | sticky;
    inc     = 1'b0;
    case (round_mode_e'(mode))
      RND_NE:   inc = guard & (sticky | kept[0]);
      RND_TZ:   inc = 1'b0;
      RND_PINF: inc = inexact & ~sign;
      RND_NINF: inc = inexact & sign;
      default:  inc = 1'b0;
    endcase
    rounded = {1'b0, kept} + {{KW{1'b0}}, inc};
    pos_ovf = !sign && (rounded > POS_LIM);
    neg_ovf = sign && (rounded > NEG_LIM);
    // Negating a zero magnitude yields zero, so no negative zero can appear.
    wrapped = sign ? -rounded[N-1:0] : rounded[N-1:0];
    res     = wrapped;
    if (sat && pos_ovf) res = {1'b0, {(N-1){1'b1}}};
    if (sat && neg_ovf) res = {1'b1, {(N-1){1'b0}}};
    // Underflow means rounding collapsed a nonzero product; wrap-to-zero is an overflow.
    oor          = '0;
    oor[OOR_POS] = pos_ovf;
    oor[OOR_NEG] = neg_ovf;
    oor[OOR_UNF] = (mag != '0) && (rounded == '0);
    oor[OOR_INX] = inexact;
  end

endmodule

// File: rtl/fxp_seqmult.sv
// Radix-2 shift-add signed fixed-point multiplier with registered round/saturate
// stage and valid/ready handshakes on both sides.
module fxp_seqmult
  import fxp_pkg::*;
#(
  parameter int P = 8,
  parameter int Q = 8,
  localparam int N = P + Q
) (
  input  logic         clk_in,
  input  logic         rst_in_N,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  input  logic [1:0]   round_in,
  input  logic         sat_in,
  input  logic         start_in,
  output logic         ready_out,
  output logic [N-1:0] p_out,
  output logic [3:0]   oor_out,
  output logic         valid_out,
  input  logic         out_ready_in
);

  localparam int CW = $clog2(N);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [2*N:0]    acc_p0;
  logic [N-1:0]    mcand_p0;
  logic            sign_p0, sat_p0;
  logic [1:0]      mode_p0;

  logic            accept;
  logic [N-1:0]    x_mag, y_mag, rs_res;
  logic [N:0]      sum;
  logic [3:0]      rs_oor;

  assign ready_out = (state == IDLE) || (state == DONE && out_ready_in);
  assign accept    = start_in && ready_out;
  // Unsigned N-bit magnitudes: the most negative value maps to 2^(N-1).
  assign x_mag     = x_in[N-1] ? -x_in : x_in;
  assign y_mag     = y_in[N-1] ? -y_in : y_in;
  assign sum       = {1'b0, acc_p0[2*N-1:N]} + {1'b0, mcand_p0};

  fxp_round_sat #(.P(P), .Q(Q)) u_round_sat (
    .mag  (acc_p0[2*N-1:0]),
    .sign (sign_p0),
    .mode (mode_p0),
    .sat  (sat_p0),
    .res  (rs_res),
    .oor  (rs_oor)
  );

  always_ff @(posedge clk_in or negedge rst_in_N) begin
    if (!rst_in_N) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_p0    <= '0;
      mcand_p0  <= '0;
      sign_p0   <= 1'b0;
      sat_p0    <= 1'b0;
      mode_p0   <= '0;
      p_out     <= '0;
      oor_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        // Shift-add stage: multiplier sits in the low half and drains out LSB first.
        MUL: begin
          if (acc_p0[0]) acc_p0 <= {1'b0, sum, acc_p0[N-1:1]};
          else           acc_p0 <= {1'b0, acc_p0[2*N:1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= RND;
        end
        // Round/saturate stage: result and status registered together.
        RND: begin
          p_out     <= rs_res;
          oor_out   <= rs_oor;
          valid_out <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready_in) begin
            valid_out <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        acc_p0   <= {{(N+1){1'b0}}, y_mag};
        mcand_p0 <= x_mag;
        sign_p0  <= x_in[N-1] ^ y_in[N-1];
        sat_p0   <= sat_in;
        mode_p0  <= round_in;
        cnt      <= CW'(N-1);
        state    <= MUL;
      end
    end
  end

endmodule

// File: tb/tb_fxp_seqmult.sv
// Directed-vector bench for fxp_seqmult at P=Q=8.
module tb_fxp_seqmult;

  logic        clk_in = 1'b0;
  logic        rst_in_N;
  logic [15:0] x_in, y_in;
  logic [1:0]  round_in;
  logic        sat_in, start_in, out_ready_in;
  logic        ready_out, valid_out;
  logic [15:0] p_out;
  logic [3:0]  oor_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  m;
    logic        s;
    logic [15:0] p;
    logic [3:0]  o;
  } vec_t;

  vec_t vecs [13] = '{
    '{16'h0180, 16'h0200, 2'd0, 1'b0, 16'h0300, 4'b0000},
    '{16'hFE80, 16'h0200, 2'd0, 1'b0, 16'hFD00, 4'b0000},
    '{16'h8000, 16'h0100, 2'd0, 1'b0, 16'h8000, 4'b0000},
    '{16'h0001, 16'h0080, 2'd0, 1'b0, 16'h0000, 4'b1100},
    '{16'h0001, 16'h0080, 2'd1, 1'b0, 16'h0000, 4'b1100},
    '{16'h0001, 16'h0080, 2'd2, 1'b0, 16'h0001, 4'b1000},
    '{16'h0001, 16'h0080, 2'd3, 1'b0, 16'h0000, 4'b1100},
    '{16'hFFFF, 16'h0080, 2'd3, 1'b0, 16'hFFFF, 4'b1000},
    '{16'h7FFF, 16'h7FFF, 2'd0, 1'b1, 16'h7FFF, 4'b1001},
    '{16'h8000, 16'h8000, 2'd0, 1'b1, 16'h7FFF, 4'b0001},
    '{16'h8000, 16'h8000, 2'd0, 1'b0, 16'h0000, 4'b0001},
    '{16'h8000, 16'h0200, 2'd0, 1'b1, 16'h8000, 4'b0010},
    '{16'h0003, 16'h0080, 2'd0, 1'b0, 16'h0002, 4'b1000}
  };

  fxp_seqmult #(.P(8), .Q(8)) dut (
    .clk_in       (clk_in),
    .rst_in_N     (rst_in_N),
    .x_in         (x_in),
    .y_in         (y_in),
    .round_in     (round_in),
    .sat_in       (sat_in),
    .start_in     (start_in),
    .ready_out    (ready_out),
    .p_out        (p_out),
    .oor_out      (oor_out),
    .valid_out    (valid_out),
    .out_ready_in (out_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic do_accept(input logic [15:0] x, input logic [15:0] y,
                           input logic [1:0] m, input logic s);
    @(negedge clk_in);
    x_in = x; y_in = y; round_in = m; sat_in = s; start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk_in); #1; cyc++;
    end while (!valid_out && cyc < 100);
  endtask

  task automatic consume();
    @(negedge clk_in);
    out_ready_in = 1'b1;
    @(posedge clk_in);
    #1 out_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in_N = 1'b0; start_in = 1'b0; out_ready_in = 1'b0;
    x_in = '0; y_in = '0; round_in = '0; sat_in = 1'b0;
    #12;
    n_checks++; if (p_out !== 16'h0000) begin n_fail++; $display("FAIL reset_p: got %h want 0000", p_out); end
    n_checks++; if (oor_out !== 4'b0000) begin n_fail++; $display("FAIL reset_oor: got %b want 0000", oor_out); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    @(negedge clk_in); rst_in_N = 1'b1; #1;
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_vectors();
    int cyc;
    for (int i = 0; i < 13; i++) begin
      do_accept(vecs[i].x, vecs[i].y, vecs[i].m, vecs[i].s);
      wait_valid(cyc);
      n_checks++; if (cyc != 17) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want 17", i, cyc); end
      n_checks++; if (p_out !== vecs[i].p) begin n_fail++; $display("FAIL vec%0d_p: got %h want %h", i, p_out, vecs[i].p); end
      n_checks++; if (oor_out !== vecs[i].o) begin n_fail++; $display("FAIL vec%0d_oor: got %b want %b", i, oor_out, vecs[i].o); end
      consume();
      n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL vec%0d_drop: got %b want 0", i, valid_out); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_accept(16'h0180, 16'h0200, 2'd0, 1'b0);
    wait_valid(cyc);
    n_checks++; if (cyc != 17) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 17", cyc); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      x_in = 16'h0100; y_in = 16'h0100; start_in = 1'b1;
      #1;
      n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL hold_ready%0d: got %b want 0", k, ready_out); end
      @(posedge clk_in); #1;
      n_checks++; if (p_out !== 16'h0300 || valid_out !== 1'b1) begin
        n_fail++; $display("FAIL hold_p%0d: got %h/%b want 0300/1", k, p_out, valid_out);
      end
    end
    @(negedge clk_in);
    x_in = 16'h0280; y_in = 16'h0200; start_in = 1'b1; out_ready_in = 1'b1;
    #1;
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", ready_out); end
    @(posedge clk_in);
    #1 start_in = 1'b0; out_ready_in = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b want 0", valid_out); end
    wait_valid(cyc);
    n_checks++; if (cyc != 17) begin n_fail++; $display("FAIL b2b_latency: got %0d want 17", cyc); end
    n_checks++; if (p_out !== 16'h0500) begin n_fail++; $display("FAIL b2b_p: got %h want 0500", p_out); end
    consume();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int spurious;
    do_accept(16'h0180, 16'h0200, 2'd0, 1'b0);
    repeat (8) @(posedge clk_in);
    #2 rst_in_N = 1'b0;
    #1;
    n_checks++; if (p_out !== 16'h0000 || oor_out !== 4'b0000 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h/%b/%b want 0000/0000/0", p_out, oor_out, valid_out);
    end
    @(negedge clk_in); rst_in_N = 1'b1; #1;
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", ready_out); end
    spurious = 0;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (valid_out) spurious++;
    end
    n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL midrst_spurious: got %0d valid cycles want 0", spurious); end
    do_accept(16'h0300, 16'hFF00, 2'd0, 1'b0);
    wait_valid(cyc);
    n_checks++; if (cyc != 17) begin n_fail++; $display("FAIL midrst_latency: got %0d want 17", cyc); end
    n_checks++; if (p_out !== 16'hFD00 || oor_out !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_p: got %h/%b want fd00/0000", p_out, oor_out);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
